// File: rtl/whack_pkg.sv
// -----------------------------------------------------------------------------
// whack_pkg
// Shared definitions for the whack-a-mole game datapath.
//   - hit_miss response codes
//   - responder state enumeration
//   - mole-selection LFSR seed and feedback taps
// -----------------------------------------------------------------------------
package whack_pkg;

    // hit_miss codes returned to the game-control FSM
    localparam logic [1:0] HM_NONE = 2'b00;
    localparam logic [1:0] HM_HIT  = 2'b01;
    localparam logic [1:0] HM_MISS = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_ARM,
        ST_PLAY,
        ST_REPORT,
        ST_UPDATE,
        ST_TREPORT,
        ST_FINISH,
        ST_DONE
    } resp_state_e;

    // The register shifts toward bit 0 and feeds the XOR of bits 0,2,3,5 into
    // bit 15, which is the Fibonacci form of polynomial taps 16,14,13,11.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR used to pick the next mole. It advances
// every clock cycle regardless of game state and reloads the seed on reset.
// Ports:
//   clk     in  1   clock
//   reset   in  1   asynchronous, active-high reset (loads LFSR_SEED)
//   o_value out 16  current LFSR contents
// -----------------------------------------------------------------------------
module lfsr16
    import whack_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] o_value
);

    logic [15:0] r_lfsr;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {^(r_lfsr & LFSR_TAPS), r_lfsr[15:1]};
        end
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/mole_responder.sv
// -----------------------------------------------------------------------------
// mole_responder
// Game-datapath responder for whack-a-mole. Answers the game-control FSM's
// handshake: selects moles, times the per-mole response window, detects
// button presses, keeps the score and runs the game timer.
// Ports:
//   clk            in  1           clock
//   reset          in  1           asynchronous, active-high reset
//   fsm_start      in  1           control FSM is in Start
//   fsm_game       in  1           control FSM is in Game
//   fsm_game_end   in  1           control FSM is in GameEnd (status only)
//   buttons        in  NUM_HOLES   player buttons, active-high, synchronized
//   hit_miss       out 2           00 none, 01 hit, 10 miss (level-held)
//   timer_signal   out 1           game time expired (level-held)
//   control_signal out 1           one-cycle "load/update done" pulse
//   mole_onehot    out NUM_HOLES   active mole, zero when none is up
//   score          out SCORE_W     saturating hit count
//   time_left      out clog2(GAME_CYCLES+1) remaining game cycles
// -----------------------------------------------------------------------------
module mole_responder
    import whack_pkg::*;
#(
    parameter int NUM_HOLES     = 4,
    parameter int GAME_CYCLES   = 200,
    parameter int WINDOW_CYCLES = 20,
    parameter int LOAD_CYCLES   = 3,
    parameter int SCORE_W       = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               fsm_start,
    input  logic                               fsm_game,
    input  logic                               fsm_game_end,
    input  logic [NUM_HOLES-1:0]               buttons,
    output logic [1:0]                         hit_miss,
    output logic                               timer_signal,
    output logic                               control_signal,
    output logic [NUM_HOLES-1:0]               mole_onehot,
    output logic [SCORE_W-1:0]                 score,
    output logic [$clog2(GAME_CYCLES+1)-1:0]   time_left
);

    localparam int IDX_W  = $clog2(NUM_HOLES);
    localparam int TIME_W = $clog2(GAME_CYCLES + 1);
    localparam int WIN_W  = $clog2(WINDOW_CYCLES + 1);
    localparam int LOAD_W = $clog2(LOAD_CYCLES + 1);

    resp_state_e          r_state, w_state_nx;
    logic [NUM_HOLES-1:0] r_btn_q, r_edge;
    logic [WIN_W-1:0]     r_win, w_win_nx;
    logic [LOAD_W-1:0]    r_load_cnt, w_load_cnt_nx;
    logic [1:0]           r_hit_miss, w_hit_miss_nx;
    logic                 r_timer_signal, w_timer_nx;
    logic                 r_control, w_control_nx;
    logic [NUM_HOLES-1:0] r_mole, w_mole_nx;
    logic [SCORE_W-1:0]   r_score, w_score_nx;
    logic [TIME_W-1:0]    r_time_left, w_time_nx;

    logic [15:0]          w_lfsr;
    logic [NUM_HOLES-1:0] w_new_mole;
    logic                 w_hit, w_any_edge, w_load_done;
    logic                 w_unused;

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .o_value (w_lfsr)
    );

    // GameEnd is implied by the Start flag that follows it, and only the low
    // LFSR bits select a hole.
    assign w_unused = ^{fsm_game_end, w_lfsr[15:IDX_W]};

    assign w_new_mole  = {{(NUM_HOLES-1){1'b0}}, 1'b1} << w_lfsr[IDX_W-1:0];
    assign w_hit       = |(r_edge & r_mole);
    assign w_any_edge  = |r_edge;
    assign w_load_done = (r_load_cnt == LOAD_W'(LOAD_CYCLES));

    // Rising edges are captured only while a mole is in play, so a press made
    // during ARM can never be credited to the mole raised afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_q <= '0;
            r_edge  <= '0;
        end else begin
            r_btn_q <= buttons;
            r_edge  <= (r_state == ST_PLAY) ? (buttons & ~r_btn_q) : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_win          <= '0;
            r_load_cnt     <= '0;
            r_hit_miss     <= HM_NONE;
            r_timer_signal <= 1'b0;
            r_control      <= 1'b0;
            r_mole         <= '0;
            r_score        <= '0;
            r_time_left    <= '0;
        end else begin
            r_state        <= w_state_nx;
            r_win          <= w_win_nx;
            r_load_cnt     <= w_load_cnt_nx;
            r_hit_miss     <= w_hit_miss_nx;
            r_timer_signal <= w_timer_nx;
            r_control      <= w_control_nx;
            r_mole         <= w_mole_nx;
            r_score        <= w_score_nx;
            r_time_left    <= w_time_nx;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves a signal unassigned, which would infer a latch.
        w_state_nx    = r_state;
        w_win_nx      = r_win;
        w_load_cnt_nx = '0;
        w_hit_miss_nx = r_hit_miss;
        w_timer_nx    = r_timer_signal;
        w_control_nx  = 1'b0;
        w_mole_nx     = r_mole;
        w_score_nx    = r_score;
        w_time_nx     = r_time_left;

        // The game clock runs from INIT exit through every in-game state and
        // sticks at zero; TREPORT and later are only reached once it is zero.
        if ((r_state inside {ST_ARM, ST_PLAY, ST_REPORT, ST_UPDATE}) &&
            (r_time_left != '0)) begin
            w_time_nx = r_time_left - 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (!fsm_start) begin
                    w_state_nx = ST_INIT;
                    w_score_nx = '0;
                    w_time_nx  = TIME_W'(GAME_CYCLES);
                    w_mole_nx  = '0;
                end
            end
            // The three load/update states share one counter; the counter is
            // zero on entry because none of them follows another directly.
            ST_INIT, ST_UPDATE, ST_FINISH: begin
                if (w_load_done) begin
                    w_control_nx = 1'b1;
                    w_state_nx   = (r_state == ST_FINISH) ? ST_DONE : ST_ARM;
                end else begin
                    w_load_cnt_nx = r_load_cnt + 1'b1;
                end
            end
            ST_ARM: begin
                if (fsm_game) begin
                    w_win_nx   = WIN_W'(WINDOW_CYCLES);
                    // With the clock already expired no mole is shown; PLAY
                    // then goes straight to the timer report.
                    if (r_time_left != '0) begin
                        w_mole_nx = w_new_mole;
                    end
                    w_state_nx = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (r_win != '0) begin
                    w_win_nx = r_win - 1'b1;
                end
                if (r_time_left == '0) begin
                    // Expiry outranks a same-cycle hit or miss; nothing is scored.
                    w_timer_nx = 1'b1;
                    w_state_nx = ST_TREPORT;
                end else if (w_hit) begin
                    w_hit_miss_nx = HM_HIT;
                    if (r_score != '1) begin
                        w_score_nx = r_score + 1'b1;
                    end
                    w_state_nx = ST_REPORT;
                end else if (w_any_edge || (r_win == '0)) begin
                    w_hit_miss_nx = HM_MISS;
                    w_state_nx    = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (!fsm_game) begin
                    w_hit_miss_nx = HM_NONE;
                    w_mole_nx     = '0;
                    w_state_nx    = ST_UPDATE;
                end
            end
            ST_TREPORT: begin
                if (!fsm_game) begin
                    w_timer_nx = 1'b0;
                    w_mole_nx  = '0;
                    w_state_nx = ST_FINISH;
                end
            end
            ST_DONE: begin
                if (fsm_start) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase

        // Start seen mid-game means the control FSM was reset underneath us.
        if (fsm_start && !(r_state inside {ST_IDLE, ST_DONE})) begin
            w_state_nx = ST_IDLE;
        end

        // Anything headed for IDLE leaves with all outputs cleared.
        if (w_state_nx == ST_IDLE) begin
            w_hit_miss_nx = HM_NONE;
            w_timer_nx    = 1'b0;
            w_control_nx  = 1'b0;
            w_mole_nx     = '0;
            w_score_nx    = '0;
            w_time_nx     = '0;
        end
    end

    assign hit_miss       = r_hit_miss;
    assign timer_signal   = r_timer_signal;
    assign control_signal = r_control;
    assign mole_onehot    = r_mole;
    assign score          = r_score;
    assign time_left      = r_time_left;

endmodule

// File: tb/tb_mole_responder.sv
// -----------------------------------------------------------------------------
// tb_mole_responder
// Directed bench for mole_responder. Score width is narrowed to 2 bits so
// saturation is reachable within a single game; all other parameters are at
// their defaults. Expected moles come from an independent LFSR model.
// -----------------------------------------------------------------------------
module tb_mole_responder;

    localparam int GAME = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic       fsm_start, fsm_game, fsm_game_end;
    logic [3:0] buttons;
    logic [1:0] hit_miss;
    logic       timer_signal, control_signal;
    logic [3:0] mole_onehot;
    logic [1:0] score;
    logic [7:0] time_left;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int x_cyc = 0;

    logic [15:0] m_lfsr, m_prev;

    mole_responder #(
        .NUM_HOLES     (4),
        .GAME_CYCLES   (GAME),
        .WINDOW_CYCLES (20),
        .LOAD_CYCLES   (3),
        .SCORE_W       (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fsm_start      (fsm_start),
        .fsm_game       (fsm_game),
        .fsm_game_end   (fsm_game_end),
        .buttons        (buttons),
        .hit_miss       (hit_miss),
        .timer_signal   (timer_signal),
        .control_signal (control_signal),
        .mole_onehot    (mole_onehot),
        .score          (score),
        .time_left      (time_left)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: x^16+x^14+x^13+x^11, right-shifting, seed ACE1.
    // m_prev holds the value that was current before the latest edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] exp_time();
        int n;
        n = cyc - x_cyc;
        return (n >= GAME) ? 32'd0 : 32'(GAME - n);
    endfunction

    // Drop Start, expect the INIT pulse LOAD_CYCLES+1 edges later.
    task automatic start_game(input string tag);
        fsm_start = 1'b0;
        tick(1);
        check({tag, " init time_left"}, time_left, GAME);
        check({tag, " init score"}, score, 0);
        tick(3);
        check({tag, " ctrl before"}, control_signal, 0);
        tick(1);
        check({tag, " ctrl pulse"}, control_signal, 1);
        x_cyc = cyc;
        check({tag, " time at exit"}, time_left, GAME);
        tick(1);
        check({tag, " ctrl width"}, control_signal, 0);
        check({tag, " time running"}, time_left, exp_time());
    endtask

    // From ARM: raise fsm_game and check the mole against the model.
    task automatic raise_mole(input string tag, output int idx);
        logic [3:0] e;
        fsm_game = 1'b1;
        tick(1);
        idx = int'(m_prev[1:0]);
        e = '0;
        e[idx] = 1'b1;
        check({tag, " mole"}, mole_onehot, e);
    endtask

    // Drop fsm_game; flags clear on that edge, UPDATE/FINISH pulses 4 later.
    task automatic close_handshake(input string tag);
        fsm_game = 1'b0;
        buttons  = '0;
        tick(1);
        check({tag, " hm drop"}, hit_miss, 0);
        check({tag, " timer drop"}, timer_signal, 0);
        check({tag, " mole clear"}, mole_onehot, 0);
        tick(3);
        check({tag, " ctrl before"}, control_signal, 0);
        tick(1);
        check({tag, " ctrl pulse"}, control_signal, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic [3:0] b;

        reset        = 1'b1;
        fsm_start    = 1'b1;
        fsm_game     = 1'b0;
        fsm_game_end = 1'b0;
        buttons      = '0;
        tick(2);
        check("rst hit_miss", hit_miss, 0);
        check("rst timer", timer_signal, 0);
        check("rst ctrl", control_signal, 0);
        check("rst mole", mole_onehot, 0);
        check("rst score", score, 0);
        check("rst time", time_left, 0);
        reset = 1'b0;
        tick(3);
        check("idle ctrl", control_signal, 0);
        check("idle time", time_left, 0);

        // ---------------- game 1 ----------------
        start_game("g1 start");

        // Hit 5 cycles after the mole rises.
        raise_mole("hit", idx);
        tick(5);
        b = '0; b[idx] = 1'b1;
        buttons = b;
        tick(1);
        check("hit latency", hit_miss, 0);
        tick(1);
        check("hit code", hit_miss, 1);
        check("hit score", score, 1);
        tick(2);
        check("hit held", hit_miss, 1);
        close_handshake("hit");

        // Wrong button.
        raise_mole("wrong", idx);
        b = '0; b[(idx + 1) % 4] = 1'b1;
        buttons = b;
        tick(1);
        check("wrong latency", hit_miss, 0);
        tick(1);
        check("wrong code", hit_miss, 2);
        check("wrong score", score, 1);
        close_handshake("wrong");

        // No press: miss WINDOW_CYCLES+1 after the rise.
        raise_mole("window", idx);
        tick(20);
        check("window early", hit_miss, 0);
        tick(1);
        check("window miss", hit_miss, 2);
        check("window time", time_left, exp_time());
        close_handshake("window");

        // Timer expiry coinciding with a correct press.
        while (cyc - x_cyc < 185) tick(1);
        check("timer pre", time_left, 15);
        raise_mole("timer", idx);
        tick(13);
        check("timer last", time_left, 1);
        b = '0; b[idx] = 1'b1;
        buttons = b;
        tick(1);
        check("timer zero", time_left, 0);
        check("timer hm quiet", hit_miss, 0);
        tick(1);
        check("timer signal", timer_signal, 1);
        check("timer no hit", hit_miss, 0);
        check("timer no score", score, 1);
        tick(1);
        check("timer held", timer_signal, 1);
        close_handshake("treport");
        tick(2);
        check("done score", score, 1);
        check("done ctrl", control_signal, 0);
        fsm_start = 1'b1;
        tick(1);
        check("idle clears score", score, 0);

        // ---------------- game 2: saturation and resync ----------------
        start_game("g2 start");
        for (int i = 0; i < 5; i++) begin
            raise_mole("sat", idx);
            b = '0; b[idx] = 1'b1;
            buttons = b;
            tick(2);
            check("sat code", hit_miss, 1);
            check("sat score", score, (i + 1 > 3) ? 3 : i + 1);
            close_handshake("sat");
        end
        raise_mole("resync", idx);
        b = '0; b[idx] = 1'b1;
        buttons = b;
        tick(2);
        check("resync hit", hit_miss, 1);
        fsm_game = 1'b0;
        buttons  = '0;
        tick(2);
        fsm_start = 1'b1;
        tick(1);
        check("resync score", score, 0);
        check("resync time", time_left, 0);
        check("resync ctrl", control_signal, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("resync no pulse", control_signal, 0);
        end
        start_game("g3 start");

        // ---------------- asynchronous reset mid-PLAY ----------------
        raise_mole("pre reset", idx);
        #3;
        reset     = 1'b1;
        fsm_start = 1'b1;
        fsm_game  = 1'b0;
        #1;
        check("async mole", mole_onehot, 0);
        check("async time", time_left, 0);
        check("async hm", hit_miss, 0);
        check("async ctrl", control_signal, 0);
        tick(2);
        reset = 1'b0;
        tick(3);
        check("post reset ctrl", control_signal, 0);
        check("post reset mole", mole_onehot, 0);
        start_game("g4 start");
        raise_mole("reseeded", idx);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mole_responder.md
# mole_responder

Game-datapath responder for the whack-a-mole game. It answers the game-control FSM's handshake: it drives `hit_miss`, `timer_signal` and `control_signal` from mole selection, per-mole response windows, button presses, score keeping and the game timer. It watches the FSM's registered state flags (`fsm_start`, `fsm_game`, `fsm_game_end`) to know which transition the FSM is waiting on.

## Interface
- `NUM_HOLES`, 4: number of holes/buttons; must be a power of two, 2..8.
- `GAME_CYCLES`, 200: game duration in clock cycles.
- `WINDOW_CYCLES`, 20: cycles a mole stays up before it counts as a miss.
- `LOAD_CYCLES`, 3: cycles of load/update work before each `control_signal` pulse; must be ≥1.
- `SCORE_W`, 8: score width.

- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `fsm_start` in 1: FSM is in Start.
- `fsm_game` in 1: FSM is in Game.
- `fsm_game_end` in 1: FSM is in GameEnd.
- `buttons` in NUM_HOLES: player buttons, active-high, already synchronized.
- `hit_miss` out 2: 00 none, 01 hit, 10 miss; registered.
- `timer_signal` out 1: game time expired; registered.
- `control_signal` out 1: one-cycle "load/update done" pulse; registered.
- `mole_onehot` out NUM_HOLES: active mole; all zeros when no mole is up.
- `score` out SCORE_W: hit count, saturating.
- `time_left` out clog2(GAME_CYCLES+1): remaining game cycles.

## Operation
States:
- **IDLE**
  - Outputs cleared.
  - Advances to INIT when `fsm_start` is low.
- **INIT**
  - On entry: `score`←0, `time_left`←GAME_CYCLES, `mole_onehot`←0.
  - Counts LOAD_CYCLES, then pulses `control_signal` and advances to ARM.
- **ARM**
  - Waits for `fsm_game` high.
  - Then loads the window counter with WINDOW_CYCLES, raises a new mole from the LFSR and enters PLAY.
- **PLAY**
  - Window counter decrements each cycle.
  - Rising edge on the active mole's button → REPORT with hit; `score`+1, saturating at all ones.
  - Rising edge on any other button, or window counter reaching 0 → REPORT with miss.
  - Several button edges in the same cycle: a hit if the mole bit is among them.
- **REPORT**
  - `hit_miss` is held until `fsm_game` is sampled low.
  - `mole_onehot`←0, then UPDATE.
- **UPDATE**
  - Counts LOAD_CYCLES, pulses `control_signal`, then goes to ARM.
- **TREPORT**
  - `timer_signal` is held until `fsm_game` is sampled low.
  - `mole_onehot`←0, then FINISH.
- **FINISH**
  - Counts LOAD_CYCLES, pulses `control_signal`, then DONE.
- **DONE**
  - `score` is frozen.
  - Goes to IDLE when `fsm_start` is high, which happens after GameEnd is acknowledged.

Game timer:
- Decrements every cycle from INIT exit until it reaches 0; it saturates at 0.
- In PLAY, `time_left`==0 → TREPORT.
  - Timer expiry wins over a same-cycle hit or miss; that hit is not scored.
- If the timer expires during REPORT, UPDATE or ARM, the current handshake completes first. TREPORT is taken on the first cycle back in PLAY, with no new mole raised.

Mole selection:
- 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1.
- Advances every cycle, including IDLE.
- Hole index = low clog2(NUM_HOLES) bits at the moment of mole raise.

Button edges:
- One register stage of `buttons`; an edge is `buttons & ~buttons_q`.
- Edges are ignored outside PLAY.

Resynchronization:
- `fsm_start` high in any state other than IDLE/DONE (FSM was reset) → IDLE next cycle, with outputs cleared.

## Timing
- Reset values:
  - `hit_miss`=00, `timer_signal`=0, `control_signal`=0, `mole_onehot`=0, `score`=0, `time_left`=0.
  - State IDLE, LFSR=16'hACE1.
- Button pressed at edge k (visible at port in cycle k) → `hit_miss` high from edge k+2 (edge register plus output register).
- Window expiry: a miss is asserted WINDOW_CYCLES+1 cycles after `mole_onehot` rises.
- `control_signal` is exactly one cycle wide, LOAD_CYCLES+1 cycles after entering INIT, UPDATE or FINISH.
- `hit_miss` and `timer_signal` are level-held. Both drop on the edge after `fsm_game` is sampled low. Holding through the FSM's one-cycle flag lag is legal; the FSM ignores them outside Game.
- `hit_miss` and `timer_signal` are never asserted together.

## Structure
- Shared package `whack_pkg`:
  - `hit_miss` codes HM_NONE/HM_HIT/HM_MISS.
  - Responder state enumeration.
  - LFSR seed and tap constants.
- One sub-module: `lfsr16`, a free-running 16-bit LFSR with reset to seed.

## Test plan
Defaults unless stated: NUM_HOLES=4, GAME_CYCLES=200, WINDOW_CYCLES=20, LOAD_CYCLES=3.
- Reset: assert `reset` mid-PLAY → all outputs zero immediately; `hit_miss`=00; IDLE after release with `fsm_start`=1.
- Start handshake: drop `fsm_start` → `control_signal` single pulse 4 cycles later; `time_left`=200; `score`=0.
- Hit: press the active mole's button 5 cycles after the mole rises → `hit_miss`=01 held until `fsm_game` low; `score`=1; `control_signal` pulse 4 cycles after `fsm_game` low; new mole on `fsm_game` high.
- Miss paths:
  - Wrong button → `hit_miss`=10, `score` unchanged.
  - No press → `hit_miss`=10 after 21 cycles.
- Timer priority: `time_left` reaches 0 in the same cycle as a correct press → `timer_signal`=1, `hit_miss`=00, `score` unchanged. After `fsm_game` low → one `control_signal` pulse; DONE; `fsm_start` high → IDLE.
- Saturation and resync:
  - SCORE_W=2, 5 hits → `score`=3.
  - `fsm_start` raised during UPDATE → IDLE next cycle; no `control_signal` pulse.
